// File: rtl/biquad8_zero_coeff_loader.sv
// Coefficient-write initiator for a bank of biquad zero-section FIR stages:
// replays each accepted (b, a) pair as two serial writes and issues a shared update strobe on commit.
module biquad8_zero_coeff_loader #(
    parameter int NTARGET     = 4,
    parameter int SELBITS     = 2,
    parameter int GAP_CYCLES  = 0,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [17:0]         b_i,
    input  logic [17:0]         a_i,
    input  logic [SELBITS-1:0]  sel_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic                commit_i,
    output logic [17:0]         coeff_dat_o,
    output logic [NTARGET-1:0]  coeff_wr_o,
    output logic [NTARGET-1:0]  coeff_update_o,
    output logic [NTARGET-1:0]  dirty_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR_B  = 3'd1;
    localparam logic [2:0] ST_GAP_B = 3'd2;
    localparam logic [2:0] ST_WR_A  = 3'd3;
    localparam logic [2:0] ST_GAP_A = 3'd4;
    localparam logic [2:0] ST_UPD   = 3'd5;

    localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
    localparam bit         AUTO     = (AUTO_COMMIT != 0);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    // An out-of-range index decodes to all zeros, which suppresses strobes and dirty updates.
    function automatic logic [NTARGET-1:0] sel_decode(input logic [SELBITS-1:0] s);
        logic [NTARGET-1:0] r;
        for (int i = 0; i < NTARGET; i++) begin
            r[i] = (int'(s) == i);
        end
        return r;
    endfunction

    logic [2:0]         state_r, state_s, post_s;
    logic [3:0]         gap_cnt_r, gap_cnt_s;
    logic [17:0]        b_r, b_s, a_r, a_s;
    logic [SELBITS-1:0] sel_r, sel_s;
    logic [NTARGET-1:0] dirty_r, dirty_s;
    logic               pend_r, pend_s, accept_s;
    logic [17:0]        dat_r, dat_s;
    logic [NTARGET-1:0] wr_r, wr_s, upd_r, upd_s;
    logic               ready_r, ready_s, busy_r, busy_s, err_r, err_s;

    // Sequencer next-state, pair latch, dirty and commit-pending bookkeeping.
    always_comb begin
        accept_s  = valid_i & ready_r;
        state_s   = state_r;
        gap_cnt_s = gap_cnt_r;
        b_s       = b_r;
        a_s       = a_r;
        sel_s     = sel_r;
        dirty_s   = dirty_r;
        pend_s    = pend_r | commit_i;
        post_s    = (AUTO || pend_r) ? ST_UPD : ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_WR_B;
                    b_s     = b_i;
                    a_s     = a_i;
                    sel_s   = sel_i;
                end else if (pend_r) begin
                    state_s = ST_UPD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_B: begin
                if (HAS_GAP) begin
                    state_s   = ST_GAP_B;
                    gap_cnt_s = GAP_LAST;
                end else begin
                    state_s = ST_WR_A;
                    dirty_s = dirty_r | sel_decode(sel_r);
                end
            end
            ST_GAP_B: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = ST_WR_A;
                    dirty_s = dirty_r | sel_decode(sel_r);
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            ST_WR_A: begin
                if (HAS_GAP) begin
                    state_s   = ST_GAP_A;
                    gap_cnt_s = GAP_LAST;
                end else begin
                    state_s = post_s;
                end
            end
            ST_GAP_A: begin
                if (gap_cnt_r == 4'd0) begin
                    state_s = post_s;
                end else begin
                    gap_cnt_s = gap_cnt_r - 4'd1;
                end
            end
            ST_UPD: begin
                // A commit arriving during the update cycle starts a fresh request.
                state_s = ST_IDLE;
                dirty_s = '0;
                pend_s  = commit_i;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so every port is a flop.
    always_comb begin
        wr_s  = '0;
        dat_s = 18'd0;
        upd_s = '0;
        err_s = 1'b0;
        case (state_s)
            ST_WR_B: begin
                wr_s  = sel_decode(sel_s);
                dat_s = (|sel_decode(sel_s)) ? b_s : 18'd0;
                err_s = ~(|sel_decode(sel_s));
            end
            ST_WR_A: begin
                wr_s  = sel_decode(sel_s);
                dat_s = (|sel_decode(sel_s)) ? a_s : 18'd0;
            end
            ST_UPD: begin
                upd_s = dirty_s;
            end
            default: begin
                wr_s = '0;
            end
        endcase
        ready_s = (state_s == ST_IDLE) && !pend_s;
        busy_s  = (state_s != ST_IDLE) || pend_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gap_cnt_r <= 4'd0;
            b_r       <= 18'd0;
            a_r       <= 18'd0;
            sel_r     <= '0;
            dirty_r   <= '0;
            pend_r    <= 1'b0;
            dat_r     <= 18'd0;
            wr_r      <= '0;
            upd_r     <= '0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            b_r       <= b_s;
            a_r       <= a_s;
            sel_r     <= sel_s;
            dirty_r   <= dirty_s;
            pend_r    <= pend_s;
            dat_r     <= dat_s;
            wr_r      <= wr_s;
            upd_r     <= upd_s;
            ready_r   <= ready_s;
            busy_r    <= busy_s;
            err_r     <= err_s;
        end
    end

    assign ready_o        = ready_r;
    assign coeff_dat_o    = dat_r;
    assign coeff_wr_o     = wr_r;
    assign coeff_update_o = upd_r;
    assign dirty_o        = dirty_r;
    assign busy_o         = busy_r;
    assign err_o          = err_r;

endmodule
